// File: rtl/psum_accumulator.sv
`default_nettype none
// ============================================================================
//  Module   : psum_accumulator
//  Purpose  : Output-side accumulation stage of the MMA datapath. Seeds each
//             output tile with the bias vector on the first partial-sum pass,
//             accumulates later K passes into a SIZE x SIZE buffer, then drains
//             the finished tile row by row toward writeback.
//  Revision : 1.0  initial release
// ============================================================================
module psum_accumulator #(
  parameter int SIZE       = 16,
  parameter int DATA_WIDTH = 32,
  parameter int REG_WIDTH  = 32
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             init_cfg,
  input  logic [REG_WIDTH-1:0]             num_k_tiles,
  input  logic                             psum_valid,
  output logic                             psum_ready,
  input  logic [SIZE-1:0][DATA_WIDTH-1:0]  psum_data,
  input  logic                             psum_last,
  input  logic [SIZE-1:0][DATA_WIDTH-1:0]  bias_in,
  input  logic                             bias_valid,
  output logic                             partial_sum_calc_over,
  output logic                             tile_calc_over,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [SIZE-1:0][DATA_WIDTH-1:0]  out_data,
  output logic                             out_last
);

  localparam int C_ROW_W = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam int C_CNT_W = $clog2(SIZE + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t                          r_state;
  state_t                          w_state_nxt;
  logic [REG_WIDTH-1:0]            r_num_k;
  logic [REG_WIDTH-1:0]            r_pass;
  logic [C_ROW_W-1:0]              r_row;
  logic [C_ROW_W-1:0]              r_drain_idx;
  logic [C_CNT_W-1:0]              r_tile_rows;
  logic [SIZE-1:0][DATA_WIDTH-1:0] r_acc [SIZE];
  logic                            r_psum_over;
  logic                            r_tile_over;

  logic                            w_pass0;
  logic                            w_psum_ready;
  logic                            w_psum_hs;
  logic                            w_row_last;
  logic                            w_pass_end;
  logic [REG_WIDTH:0]              w_pass_inc;
  logic                            w_final_pass;
  logic                            w_out_hs;
  logic                            w_drain_last;
  logic [SIZE-1:0][DATA_WIDTH-1:0] w_row_sum;

  assign w_pass0      = (r_pass == '0);
  // Pass 0 needs the bias vector to seed the row; later passes do not.
  assign w_psum_ready = (r_state == ST_ACC) && (!w_pass0 || bias_valid);
  assign w_psum_hs    = psum_valid && w_psum_ready;
  // A pass also ends when the buffer's last row is written, even without psum_last.
  assign w_row_last   = psum_last || (r_row == C_ROW_W'(SIZE - 1));
  assign w_pass_end   = w_psum_hs && w_row_last;
  // One extra bit so a num_k of all-ones cannot wrap the comparison.
  assign w_pass_inc   = {1'b0, r_pass} + {{REG_WIDTH{1'b0}}, 1'b1};
  assign w_final_pass = (w_pass_inc == {1'b0, r_num_k});
  assign w_out_hs     = (r_state == ST_DRAIN) && out_ready;
  assign w_drain_last = ((C_CNT_W'(r_drain_idx) + C_CNT_W'(1)) == r_tile_rows);

  assign partial_sum_calc_over = r_psum_over;
  assign tile_calc_over        = r_tile_over;

  // Lane-wise adder: bias seeds the row on pass 0, stored value on later passes.
  genvar gi;
  generate
    for (gi = 0; gi < SIZE; gi++) begin : g_lane
      assign w_row_sum[gi] = psum_data[gi] + (w_pass0 ? bias_in[gi] : r_acc[r_row][gi]);
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode and handshake-side outputs.
  always_comb begin
    w_state_nxt = r_state;
    psum_ready  = 1'b0;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    out_data    = '0;
    case (r_state)
      ST_IDLE: begin
        w_state_nxt = ST_IDLE;
      end
      ST_ACC: begin
        psum_ready = w_psum_ready;
        if (w_pass_end && w_final_pass) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        out_valid = 1'b1;
        out_data  = r_acc[r_drain_idx];
        out_last  = w_drain_last;
        if (w_out_hs && w_drain_last) begin
          w_state_nxt = ST_ACC;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    // Reconfiguration restarts the tile from any state.
    if (init_cfg) begin
      w_state_nxt = ST_ACC;
    end
  end

  // Pass, row, drain and tile-height bookkeeping plus the num_k latch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num_k     <= REG_WIDTH'(1);
      r_pass      <= '0;
      r_row       <= '0;
      r_drain_idx <= '0;
      r_tile_rows <= '0;
    end else if (init_cfg) begin
      r_num_k     <= (num_k_tiles == '0) ? REG_WIDTH'(1) : num_k_tiles;
      r_pass      <= '0;
      r_row       <= '0;
      r_drain_idx <= '0;
      r_tile_rows <= '0;
    end else begin
      if (w_psum_hs) begin
        if (w_row_last) begin
          r_row <= '0;
          if (w_pass0) begin
            r_tile_rows <= C_CNT_W'(r_row) + C_CNT_W'(1);
          end
          r_pass <= w_final_pass ? '0 : w_pass_inc[REG_WIDTH-1:0];
        end else begin
          r_row <= r_row + C_ROW_W'(1);
        end
      end
      if (w_out_hs) begin
        r_drain_idx <= w_drain_last ? '0 : (r_drain_idx + C_ROW_W'(1));
      end
    end
  end

  // Registered status pulses; a config strobe swallows the pulse of its cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_psum_over <= 1'b0;
      r_tile_over <= 1'b0;
    end else begin
      r_psum_over <= !init_cfg && w_pass_end;
      r_tile_over <= !init_cfg && w_out_hs && w_drain_last;
    end
  end

  // Accumulation buffer write; contents survive reconfiguration by design.
  always_ff @(posedge clk) begin
    if (w_psum_hs) begin
      r_acc[r_row] <= w_row_sum;
    end
  end

endmodule
`default_nettype wire
